// File: rtl/keypad_pkg.sv
// Shared types, row-drive constants and small helpers for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int unsigned KEY_CODE_W = 4;

  localparam logic [3:0] ROW0 = 4'b1110;
  localparam logic [3:0] ROW1 = 4'b1101;
  localparam logic [3:0] ROW2 = 4'b1011;
  localparam logic [3:0] ROW3 = 4'b0111;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    SINGLE,
    MULTI
  } frame_t;

  function automatic logic [3:0] row_drive(input logic [1:0] idx);
    logic [3:0] r;
    case (idx)
      2'd0:    r = ROW0;
      2'd1:    r = ROW1;
      2'd2:    r = ROW2;
      default: r = ROW3;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    logic [2:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < 4; i++) cnt = cnt + {2'b00, v[i]};
    return cnt;
  endfunction

  // Index of the lowest active-low column; only meaningful when exactly one is low.
  function automatic logic [1:0] low_col(input logic [3:0] col);
    logic [1:0] idx;
    logic       found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!col[i] && !found) begin
        idx   = 2'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad-side and event-side signals of the scanner, grouped for connection.
interface keypad_scan_if;
  import keypad_pkg::*;

  logic [3:0]            Key_Col;
  logic [3:0]            Key_Row;
  logic [KEY_CODE_W-1:0] Key_Code;
  logic                  Key_Valid;
  logic                  Key_Down;
  logic                  Key_Ghost;

  modport master (
    input  Key_Col,
    output Key_Row, Key_Code, Key_Valid, Key_Down, Key_Ghost
  );

  modport slave (
    output Key_Col,
    input  Key_Row, Key_Code, Key_Valid, Key_Down, Key_Ghost
  );
endinterface

// File: rtl/keypad_frame_collector.sv
// Column synchronizer, row rotation with dwell timing, and per-frame key classification.
module keypad_frame_collector
  import keypad_pkg::*;
#(
  parameter int unsigned ROW_DWELL = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            key_col,
  output logic [3:0]            key_row,
  output logic                  frame_done,
  output frame_t                frame_result,
  output logic [KEY_CODE_W-1:0] frame_code
);

  localparam int unsigned DW = (ROW_DWELL > 1) ? $clog2(ROW_DWELL) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(ROW_DWELL - 1);

  logic [3:0]            col_meta;
  logic [3:0]            col_sync;
  logic [DW-1:0]         dwell;
  logic [1:0]            row_idx;
  logic [1:0]            acc_cnt;
  logic [KEY_CODE_W-1:0] acc_code;
  logic                  dwell_end;
  logic [2:0]            row_lows;
  logic [2:0]            sum;
  logic [1:0]            cnt_nxt;
  logic [KEY_CODE_W-1:0] code_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta <= '1;
      col_sync <= '1;
    end else begin
      col_meta <= key_col;
      col_sync <= col_meta;
    end
  end

  assign dwell_end = (dwell == DWELL_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell   <= '0;
      row_idx <= '0;
      key_row <= ROW0;
    end else if (dwell_end) begin
      dwell   <= '0;
      row_idx <= row_idx + 2'd1;
      key_row <= row_drive(row_idx + 2'd1);
    end else begin
      dwell <= dwell + DW'(1);
    end
  end

  // Running low-bit count saturates at 2 so MULTI survives later rows.
  always_comb begin
    row_lows = popcnt4(~col_sync);
    sum      = {1'b0, acc_cnt} + row_lows;
    cnt_nxt  = (sum > 3'd1) ? 2'd2 : sum[1:0];
    code_nxt = acc_code;
    if (acc_cnt == 2'd0 && row_lows == 3'd1) code_nxt = {row_idx, low_col(col_sync)};
    frame_done = dwell_end && (row_idx == 2'd3);
    case (cnt_nxt)
      2'd0:    frame_result = NONE;
      2'd1:    frame_result = SINGLE;
      default: frame_result = MULTI;
    endcase
    frame_code = code_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt  <= '0;
      acc_code <= '0;
    end else if (dwell_end) begin
      if (row_idx == 2'd3) begin
        acc_cnt  <= '0;
        acc_code <= '0;
      end else begin
        acc_cnt  <= cnt_nxt;
        acc_code <= code_nxt;
      end
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: frame collector plus press/release debounce FSM and event outputs.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned ROW_DWELL = 50000,
  parameter int unsigned DEB_SCANS = 20
) (
  input  logic          CLK,
  input  logic          RSTn,
  keypad_scan_if.master kp
);

  localparam int unsigned FCW = $clog2(DEB_SCANS + 1);
  localparam logic [FCW-1:0] FCNT_MAX = FCW'(DEB_SCANS);

  logic                  frame_done;
  frame_t                frame_result;
  logic [KEY_CODE_W-1:0] frame_code;

  state_t                state_q, state_d;
  logic [FCW-1:0]        fcnt_q, fcnt_d, fcnt_inc;
  logic [KEY_CODE_W-1:0] cand_q, cand_d;
  logic [KEY_CODE_W-1:0] code_q, code_d;
  logic                  valid_q, valid_d;
  logic                  down_q, down_d;
  logic                  ghost_q, ghost_d;

  keypad_frame_collector #(
    .ROW_DWELL (ROW_DWELL)
  ) u_collector (
    .clk          (CLK),
    .rst_n        (RSTn),
    .key_col      (kp.Key_Col),
    .key_row      (kp.Key_Row),
    .frame_done   (frame_done),
    .frame_result (frame_result),
    .frame_code   (frame_code)
  );

  assign fcnt_inc = (fcnt_q == FCNT_MAX) ? fcnt_q : fcnt_q + FCW'(1);

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    cand_d  = cand_q;
    code_d  = code_q;
    valid_d = 1'b0;
    down_d  = down_q;
    ghost_d = ghost_q;
    if (frame_done) begin
      ghost_d = (frame_result == MULTI);
      case (state_q)
        IDLE: begin
          if (frame_result == SINGLE) begin
            state_d = DEBOUNCE;
            cand_d  = frame_code;
            fcnt_d  = FCW'(1);
          end
        end
        DEBOUNCE: begin
          if (frame_result == SINGLE && frame_code == cand_q) begin
            if (fcnt_inc == FCNT_MAX) begin
              state_d = HELD;
              code_d  = cand_q;
              valid_d = 1'b1;
              down_d  = 1'b1;
              fcnt_d  = '0;
            end else begin
              fcnt_d = fcnt_inc;
            end
          end else begin
            state_d = IDLE;
            fcnt_d  = '0;
          end
        end
        HELD: begin
          if (frame_result == NONE) begin
            state_d = RELEASE;
            fcnt_d  = FCW'(1);
          end
        end
        RELEASE: begin
          if (frame_result == NONE) begin
            if (fcnt_inc == FCNT_MAX) begin
              state_d = IDLE;
              down_d  = 1'b0;
              fcnt_d  = '0;
            end else begin
              fcnt_d = fcnt_inc;
            end
          end else begin
            state_d = HELD;
            fcnt_d  = '0;
          end
        end
        default: begin
          state_d = IDLE;
          fcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      fcnt_q  <= '0;
      cand_q  <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      down_q  <= 1'b0;
      ghost_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      cand_q  <= cand_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      down_q  <= down_d;
      ghost_q <= ghost_d;
    end
  end

  assign kp.Key_Code  = code_q;
  assign kp.Key_Valid = valid_q;
  assign kp.Key_Down  = down_q;
  assign kp.Key_Ghost = ghost_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Frame-level bench for keypad_scan with a behavioural 4x4 key matrix (ROW_DWELL=4, DEB_SCANS=3).
module tb_keypad_scan;

  typedef struct {
    logic [15:0] keys;
    logic        exp_valid;
    logic [3:0]  exp_code;
    logic        exp_down;
    logic        exp_ghost;
  } vec_t;

  logic        CLK;
  logic        RSTn;
  logic [15:0] keys;
  logic [3:0]  col;

  int unsigned errors;
  int unsigned checks;

  vec_t vecs[37];
  vec_t sb_q[$];

  keypad_scan_if kp();

  keypad_scan #(
    .ROW_DWELL (4),
    .DEB_SCANS (3)
  ) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .kp   (kp)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Pressed key pulls its column low while its row is driven.
  always_comb begin
    col = '1;
    for (int r = 0; r < 4; r++)
      if (!kp.Key_Row[r])
        for (int c = 0; c < 4; c++)
          if (keys[r*4+c]) col[c] = 1'b0;
  end
  assign kp.Key_Col = col;

  function automatic vec_t mk(input logic [15:0] k, input logic v, input logic [3:0] c,
                              input logic d, input logic g);
    vec_t t;
    t.keys = k; t.exp_valid = v; t.exp_code = c; t.exp_down = d; t.exp_ghost = g;
    return t;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Entered at a negedge just after a frame boundary; leaves at the negedge after the next one.
  task automatic run_frame(input vec_t v, input string tag);
    vec_t e;
    int   pulses;
    sb_q.push_back(v);
    keys   = v.keys;
    pulses = 0;
    repeat (16) begin
      @(posedge CLK);
      @(negedge CLK);
      if (kp.Key_Valid) pulses++;
    end
    e = sb_q.pop_front();
    check({tag, " valid_pulses"}, 16'(pulses), 16'(e.exp_valid));
    check({tag, " code"},  16'(kp.Key_Code),  16'(e.exp_code));
    check({tag, " down"},  16'(kp.Key_Down),  16'(e.exp_down));
    check({tag, " ghost"}, 16'(kp.Key_Ghost), 16'(e.exp_ghost));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " row"},   16'(kp.Key_Row),   16'h000e);
    check({tag, " code"},  16'(kp.Key_Code),  16'h0000);
    check({tag, " valid"}, 16'(kp.Key_Valid), 16'h0000);
    check({tag, " down"},  16'(kp.Key_Down),  16'h0000);
    check({tag, " ghost"}, 16'(kp.Key_Ghost), 16'h0000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] row_exp [4];
    errors = 0;
    checks = 0;
    keys   = '0;
    RSTn   = 1'b0;

    row_exp = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

    // keys: k9=0200 k0+k5=0021 k15=8000 k3=0008 k2=0004 k7=0080
    vecs[0]  = mk(16'h0200, 0, 4'd0,  0, 0);
    vecs[1]  = mk(16'h0200, 0, 4'd0,  0, 0);
    vecs[2]  = mk(16'h0200, 1, 4'd9,  1, 0);
    vecs[3]  = mk(16'h0200, 0, 4'd9,  1, 0);
    vecs[4]  = mk(16'h0200, 0, 4'd9,  1, 0);
    vecs[5]  = mk(16'h0200, 0, 4'd9,  1, 0);
    vecs[6]  = mk(16'h0000, 0, 4'd9,  1, 0);
    vecs[7]  = mk(16'h0000, 0, 4'd9,  1, 0);
    vecs[8]  = mk(16'h0200, 0, 4'd9,  1, 0);
    vecs[9]  = mk(16'h0000, 0, 4'd9,  1, 0);
    vecs[10] = mk(16'h0000, 0, 4'd9,  1, 0);
    vecs[11] = mk(16'h0000, 0, 4'd9,  0, 0);
    vecs[12] = mk(16'h0200, 0, 4'd9,  0, 0);
    vecs[13] = mk(16'h0000, 0, 4'd9,  0, 0);
    vecs[14] = mk(16'h0200, 0, 4'd9,  0, 0);
    vecs[15] = mk(16'h0000, 0, 4'd9,  0, 0);
    vecs[16] = mk(16'h0021, 0, 4'd9,  0, 1);
    vecs[17] = mk(16'h0021, 0, 4'd9,  0, 1);
    vecs[18] = mk(16'h0021, 0, 4'd9,  0, 1);
    vecs[19] = mk(16'h0021, 0, 4'd9,  0, 1);
    vecs[20] = mk(16'h0000, 0, 4'd9,  0, 0);
    vecs[21] = mk(16'h8000, 0, 4'd9,  0, 0);
    vecs[22] = mk(16'h8000, 0, 4'd9,  0, 0);
    vecs[23] = mk(16'h8000, 1, 4'd15, 1, 0);
    vecs[24] = mk(16'h0008, 0, 4'd15, 1, 0);
    vecs[25] = mk(16'h0021, 0, 4'd15, 1, 1);
    vecs[26] = mk(16'h0000, 0, 4'd15, 1, 0);
    vecs[27] = mk(16'h0000, 0, 4'd15, 1, 0);
    vecs[28] = mk(16'h0000, 0, 4'd15, 0, 0);
    vecs[29] = mk(16'h0004, 0, 4'd15, 0, 0);
    vecs[30] = mk(16'h0080, 0, 4'd15, 0, 0);
    vecs[31] = mk(16'h0080, 0, 4'd15, 0, 0);
    vecs[32] = mk(16'h0080, 0, 4'd15, 0, 0);
    vecs[33] = mk(16'h0080, 1, 4'd7,  1, 0);
    vecs[34] = mk(16'h0000, 0, 4'd7,  1, 0);
    vecs[35] = mk(16'h0000, 0, 4'd7,  1, 0);
    vecs[36] = mk(16'h0000, 0, 4'd7,  0, 0);

    repeat (3) @(negedge CLK);
    check_reset_outputs("in_reset");
    RSTn = 1'b1;

    for (int i = 1; i <= 16; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (i % 4 == 0) check($sformatf("row_after_%0d", i), 16'(kp.Key_Row), 16'(row_exp[i/4-1]));
    end

    for (int i = 0; i < 37; i++) run_frame(vecs[i], $sformatf("f%0d", i));

    // Reset while debouncing key 9 with two matching frames already counted.
    run_frame(mk(16'h0200, 0, 4'd7, 0, 0), "ar_a");
    run_frame(mk(16'h0200, 0, 4'd7, 0, 0), "ar_b");
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    #2 RSTn = 1'b0;
    #1 check_reset_outputs("async_rst");
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    run_frame(mk(16'h0200, 0, 4'd0, 0, 0), "post_rst_1");
    run_frame(mk(16'h0200, 0, 4'd0, 0, 0), "post_rst_2");
    run_frame(mk(16'h0200, 1, 4'd9, 1, 0), "post_rst_3");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
